// File: rtl/dma_xfer_timing.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_xfer_timing : single-transfer bus timing engine, per-channel address/  |
// |                   count registers, strobes, DACK, EOP and TC status.       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module dma_xfer_timing #(
    parameter int AW  = 16,
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] dack_in,
    input  logic           hlda,
    input  logic           ready,
    input  logic           prog_we,
    input  logic [1:0]     prog_ch,
    input  logic [1:0]     prog_sel,
    input  logic [AW-1:0]  prog_data,
    input  logic           tc_clr,
    output logic           hrq,
    output logic [NCH-1:0] dack,
    output logic [AW-1:0]  addr,
    output logic           memr_n,
    output logic           memw_n,
    output logic           ior_n,
    output logic           iow_n,
    output logic           eop_n,
    output logic [NCH-1:0] tc_status,
    output logic           busy
);

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic            hrq_q, hrq_d;
    logic [NCH-1:0]  dack_q, dack_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            memr_q, memr_d, memw_q, memw_d;
    logic            ior_q, ior_d, iow_q, iow_d, eop_q, eop_d;
    logic [NCH-1:0]  tc_q, tc_d;
    logic [AW-1:0]   base_addr_q [NCH], base_addr_d [NCH];
    logic [AW-1:0]   base_cnt_q  [NCH], base_cnt_d  [NCH];
    logic [AW-1:0]   cur_addr_q  [NCH], cur_addr_d  [NCH];
    logic [AW-1:0]   cur_cnt_q   [NCH], cur_cnt_d   [NCH];
    logic [1:0]      mode_q      [NCH], mode_d      [NCH];

    logic [1:0]      w_first_ch;
    logic            w_locked;
    logic [NCH-1:0]  w_tc_set;
    logic [1:0]      w_mode;
    logic            w_wr_mode, w_rd_mode, w_rd_phase, w_wr_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SI;
            ch_q    <= '0;
            hrq_q   <= 1'b0;
            dack_q  <= '0;
            addr_q  <= '0;
            memr_q  <= 1'b1;
            memw_q  <= 1'b1;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            eop_q   <= 1'b1;
            tc_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                base_addr_q[i] <= '0;
                base_cnt_q[i]  <= '0;
                cur_addr_q[i]  <= '0;
                cur_cnt_q[i]   <= '0;
                mode_q[i]      <= 2'b00;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            hrq_q       <= hrq_d;
            dack_q      <= dack_d;
            addr_q      <= addr_d;
            memr_q      <= memr_d;
            memw_q      <= memw_d;
            ior_q       <= ior_d;
            iow_q       <= iow_d;
            eop_q       <= eop_d;
            tc_q        <= tc_d;
            base_addr_q <= base_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_addr_q  <= cur_addr_d;
            cur_cnt_q   <= cur_cnt_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        addr_d      = addr_q;
        base_addr_d = base_addr_q;
        base_cnt_d  = base_cnt_q;
        cur_addr_d  = cur_addr_q;
        cur_cnt_d   = cur_cnt_q;
        mode_d      = mode_q;
        w_tc_set    = '0;
        w_first_ch  = '0;

        for (int i = NCH - 1; i >= 0; i--) begin
            if (dack_in[i]) w_first_ch = 2'(i);
        end

        // In S0 the channel about to be latched is already protected.
        if (state_q == S0)
            w_locked = (|dack_in) && (prog_ch == w_first_ch);
        else
            w_locked = (state_q != SI) && (prog_ch == ch_q);

        if (prog_we && !w_locked) begin
            case (prog_sel)
                2'd0: begin
                    base_addr_d[prog_ch] = prog_data;
                    cur_addr_d[prog_ch]  = prog_data;
                end
                2'd1: begin
                    base_cnt_d[prog_ch] = prog_data;
                    cur_cnt_d[prog_ch]  = prog_data;
                end
                2'd2:    mode_d[prog_ch] = prog_data[1:0];
                default: ;
            endcase
        end

        case (state_q)
            SI: if (|dack_in) state_d = S0;
            S0: begin
                if (hlda) begin
                    if (|dack_in) begin
                        state_d = S1;
                        ch_d    = w_first_ch;
                        addr_d  = cur_addr_q[w_first_ch];
                    end else begin
                        state_d = SI;
                    end
                end
            end
            S1: state_d = S2;
            S2: state_d = S3;
            S3: state_d = ready ? S4 : SW;
            SW: if (ready) state_d = S4;
            S4: begin
                state_d = SI;
                if (cur_cnt_q[ch_q] == '0) begin
                    w_tc_set[ch_q]   = 1'b1;
                    cur_addr_d[ch_q] = base_addr_q[ch_q];
                    cur_cnt_d[ch_q]  = base_cnt_q[ch_q];
                end else begin
                    cur_addr_d[ch_q] = cur_addr_q[ch_q] + AW'(1);
                    cur_cnt_d[ch_q]  = cur_cnt_q[ch_q] - AW'(1);
                end
            end
            default: state_d = SI;
        endcase

        tc_d = (tc_clr ? '0 : tc_q) | w_tc_set;

        // Outputs are registered from the next state so they line up with it.
        w_mode     = mode_q[ch_d];
        w_wr_mode  = (w_mode == 2'b01);
        w_rd_mode  = (w_mode == 2'b10);
        w_rd_phase = (state_d == S2) || (state_d == S3) || (state_d == SW);
        w_wr_phase = (state_d == S3) || (state_d == SW);

        hrq_d  = (state_d != SI);
        dack_d = (state_d inside {S1, S2, S3, SW, S4}) ? (NCH'(1) << ch_d) : '0;
        ior_d  = !(w_wr_mode && w_rd_phase);
        memw_d = !(w_wr_mode && w_wr_phase);
        memr_d = !(w_rd_mode && w_rd_phase);
        iow_d  = !(w_rd_mode && w_wr_phase);
        eop_d  = !((state_d == S4) && (cur_cnt_q[ch_d] == '0));
    end

    assign hrq       = hrq_q;
    assign dack      = dack_q;
    assign addr      = addr_q;
    assign memr_n    = memr_q;
    assign memw_n    = memw_q;
    assign ior_n     = ior_q;
    assign iow_n     = iow_q;
    assign eop_n     = eop_q;
    assign tc_status = tc_q;
    assign busy      = (state_q != SI);

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_timing.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dma_xfer_timing : directed stimulus with a transfer scoreboard.         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dma_xfer_timing;

    logic        clk;
    logic        reset_n;
    logic [3:0]  dack_in;
    logic        hlda;
    logic        ready;
    logic        prog_we;
    logic [1:0]  prog_ch;
    logic [1:0]  prog_sel;
    logic [15:0] prog_data;
    logic        tc_clr;
    logic        hrq;
    logic [3:0]  dack;
    logic [15:0] addr;
    logic        memr_n, memw_n, ior_n, iow_n, eop_n;
    logic [3:0]  tc_status;
    logic        busy;

    dma_xfer_timing #(.AW(16), .NCH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dack_in   (dack_in),
        .hlda      (hlda),
        .ready     (ready),
        .prog_we   (prog_we),
        .prog_ch   (prog_ch),
        .prog_sel  (prog_sel),
        .prog_data (prog_data),
        .tc_clr    (tc_clr),
        .hrq       (hrq),
        .dack      (dack),
        .addr      (addr),
        .memr_n    (memr_n),
        .memw_n    (memw_n),
        .ior_n     (ior_n),
        .iow_n     (iow_n),
        .eop_n     (eop_n),
        .tc_status (tc_status),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One observed transfer: strobe mask is {memr,memw,ior,iow} ever low.
    typedef struct packed {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic [3:0]  mask;
        logic [7:0]  cyc;
        logic [7:0]  rd;
        logic [7:0]  wr;
        logic [7:0]  eopc;
        logic        eopl;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    int    viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] dk, input logic [15:0] ad, input logic [3:0] mk,
                        input int cyc, input int rd, input int wr, input logic eop);
        xfer_t e;
        e.dack = dk;  e.addr = ad;  e.mask = mk;
        e.cyc  = 8'(cyc); e.rd = 8'(rd); e.wr = 8'(wr);
        e.eopc = {7'd0, eop}; e.eopl = eop;
        exp_q.push_back(e);
    endtask

    // Monitor: builds a transfer record while dack is high, scores it when dack drops.
    initial begin
        xfer_t cur;
        xfer_t e;
        logic  in_x;
        in_x = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_x = 1'b0;
            end else if (dack != 4'b0000) begin
                if (!in_x) begin
                    in_x = 1'b1;
                    cur = '0;
                    cur.dack = dack;
                    cur.addr = addr;
                end
                cur.cyc  = cur.cyc + 8'd1;
                cur.mask = cur.mask | {~memr_n, ~memw_n, ~ior_n, ~iow_n};
                if (!memr_n || !ior_n) cur.rd = cur.rd + 8'd1;
                if (!memw_n || !iow_n) cur.wr = cur.wr + 8'd1;
                if (!eop_n) cur.eopc = cur.eopc + 8'd1;
                cur.eopl = ~eop_n;
            end else begin
                if (in_x) begin
                    in_x = 1'b0;
                    done_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL xfer%0d: unexpected transfer dack=%b addr=%h", done_cnt, cur.dack, cur.addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL xfer%0d: got dack=%b addr=%h mask=%b cyc=%0d rd=%0d wr=%0d eop=%0d/%0d expected dack=%b addr=%h mask=%b cyc=%0d rd=%0d wr=%0d eop=%0d/%0d",
                                     done_cnt, cur.dack, cur.addr, cur.mask, cur.cyc, cur.rd, cur.wr, cur.eopc, cur.eopl,
                                     e.dack, e.addr, e.mask, e.cyc, e.rd, e.wr, e.eopc, e.eopl);
                        end
                    end
                end
                if (!memr_n || !memw_n || !ior_n || !iow_n || !eop_n) viol++;
            end
        end
    end

    task automatic prog(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_ch = ch; prog_sel = sel; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic wait_dack(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (dack == 4'b0000 && n < 200);
        check(name, {31'd0, dack != 4'b0000}, 32'd1);
    endtask

    task automatic wait_eop(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (eop_n && n < 200);
        check(name, {31'd0, eop_n}, 32'd0);
    endtask

    task automatic wait_wr(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (memw_n && iow_n && n < 200);
        check(name, {31'd0, memw_n && iow_n}, 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic one_xfer(input logic [3:0] dk, input string name);
        dack_in = dk;
        wait_dack(name);
        dack_in = 4'b0000;
        wait_idle(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hrq"},    {31'd0, hrq}, 32'd0);
        check({tag, "_dack"},   {28'd0, dack}, 32'd0);
        check({tag, "_addr"},   {16'd0, addr}, 32'd0);
        check({tag, "_strobe"}, {27'd0, memr_n, memw_n, ior_n, iow_n, eop_n}, 32'h1f);
        check({tag, "_tc"},     {28'd0, tc_status}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; dack_in = 4'b0000; hlda = 1'b0; ready = 1'b1;
        prog_we = 1'b0; prog_ch = 2'd0; prog_sel = 2'd0; prog_data = 16'h0000; tc_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        reset_n = 1'b1;

        // Three write transfers on ch0, TC on the third, then reload.
        prog(2'd0, 2'd0, 16'h1000);
        prog(2'd0, 2'd1, 16'h0002);
        prog(2'd0, 2'd2, 16'h0001);
        push(4'b0001, 16'h1000, 4'b0110, 4, 2, 1, 1'b0);
        push(4'b0001, 16'h1001, 4'b0110, 4, 2, 1, 1'b0);
        push(4'b0001, 16'h1002, 4'b0110, 4, 2, 1, 1'b1);
        hlda = 1'b1;
        dack_in = 4'b0001;
        wait_eop("t1_eop");
        dack_in = 4'b0000;
        wait_idle("t1_idle");
        check("t1_tc", {28'd0, tc_status}, 32'h1);
        push(4'b0001, 16'h1000, 4'b0110, 4, 2, 1, 1'b0);
        one_xfer(4'b0001, "t1_reload");

        // ch2 read, three wait states, single transfer with TC.
        prog(2'd2, 2'd0, 16'h0040);
        prog(2'd2, 2'd1, 16'h0000);
        prog(2'd2, 2'd2, 16'h0002);
        push(4'b0100, 16'h0040, 4'b1001, 7, 5, 4, 1'b1);
        ready = 1'b0;
        dack_in = 4'b0100;
        wait_wr("t2_s3");
        dack_in = 4'b0000;
        repeat (3) @(negedge clk);
        ready = 1'b1;
        wait_idle("t2_idle");
        check("t2_tc", {28'd0, tc_status}, 32'h5);

        // ch1 address wraps from FFFF to 0000.
        prog(2'd1, 2'd0, 16'hFFFF);
        prog(2'd1, 2'd1, 16'h0001);
        prog(2'd1, 2'd2, 16'h0001);
        push(4'b0010, 16'hFFFF, 4'b0110, 4, 2, 1, 1'b0);
        push(4'b0010, 16'h0000, 4'b0110, 4, 2, 1, 1'b1);
        dack_in = 4'b0010;
        wait_eop("t3_eop");
        dack_in = 4'b0000;
        wait_idle("t3_idle");
        check("t3_tc", {28'd0, tc_status}, 32'h7);

        // Request withdrawn while hlda is withheld.
        hlda = 1'b0;
        dack_in = 4'b0100;
        repeat (6) @(negedge clk);
        check("t4_hrq_hi", {31'd0, hrq}, 32'd1);
        check("t4_busy_hi", {31'd0, busy}, 32'd1);
        check("t4_dack_lo", {28'd0, dack}, 32'd0);
        dack_in = 4'b0000;
        @(negedge clk);
        hlda = 1'b1;
        @(negedge clk);
        check("t4_hrq_lo", {31'd0, hrq}, 32'd0);
        check("t4_busy_lo", {31'd0, busy}, 32'd0);

        // Writes during an active ch3 transfer: ch3 locked, ch0 accepted.
        prog(2'd3, 2'd0, 16'h3000);
        prog(2'd3, 2'd1, 16'h0005);
        prog(2'd3, 2'd2, 16'h0001);
        push(4'b1000, 16'h3000, 4'b0110, 4, 2, 1, 1'b0);
        dack_in = 4'b1000;
        wait_dack("t5_dack");
        dack_in = 4'b0000;
        prog_we = 1'b1; prog_ch = 2'd3; prog_sel = 2'd0; prog_data = 16'h5555;
        @(negedge clk);
        prog_ch = 2'd0; prog_data = 16'h0777;
        @(negedge clk);
        prog_we = 1'b0;
        wait_idle("t5_idle");
        push(4'b1000, 16'h3001, 4'b0110, 4, 2, 1, 1'b0);
        one_xfer(4'b1000, "t5_ch3");
        push(4'b0001, 16'h0777, 4'b0110, 4, 2, 1, 1'b0);
        one_xfer(4'b0001, "t5_ch0");

        // Reset asserted in S3 of a ch3 transfer.
        ready = 1'b0;
        dack_in = 4'b1000;
        wait_wr("t5_s3");
        reset_n = 1'b0;
        dack_in = 4'b0000;
        #1;
        check_reset_outputs("t5_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ready = 1'b1;

        // Verify mode on ch1; tc_clr coincides with the TC set.
        prog(2'd1, 2'd0, 16'h0200);
        prog(2'd1, 2'd1, 16'h0001);
        prog(2'd1, 2'd2, 16'h0000);
        push(4'b0010, 16'h0200, 4'b0000, 4, 0, 0, 1'b0);
        push(4'b0010, 16'h0201, 4'b0000, 4, 0, 0, 1'b1);
        dack_in = 4'b0010;
        wait_eop("t6_eop");
        dack_in = 4'b0000;
        tc_clr = 1'b1;
        @(posedge clk); #1;
        tc_clr = 1'b0;
        wait_idle("t6_idle");
        check("t6_tc_set_wins", {28'd0, tc_status}, 32'h2);
        @(negedge clk);
        tc_clr = 1'b1;
        @(negedge clk);
        tc_clr = 1'b0;
        @(negedge clk);
        check("t6_tc_clr", {28'd0, tc_status}, 32'h0);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        check("xfer_count", done_cnt, 32'd12);
        check("idle_strobes", viol, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_xfer_timing.md
Name: dma_xfer_timing

Overview:
- Transfer-timing engine of the 4-channel DMA controller; sits directly downstream of the channel priority logic.
- Takes the priority grant (one-hot dack_in) and runs one bus cycle per request: hold request, hold acknowledge, address, strobes, wait states, update.
- Owns the per-channel current address/count registers.
- Drives the system address, the bus strobes, the registered DACK and end-of-process.

Parameters:
- AW, 16, address and count width.
- NCH, 4, number of channels. Fixed at 4; it matches the 4-bit grant vector.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dack_in  in  NCH  one-hot grant from priority logic; all-zero means no request pending.
- hlda  in  1  hold acknowledge from the CPU.
- ready  in  1  memory/IO ready; low inserts wait states.
- prog_we  in  1  register-write strobe.
- prog_ch  in  2  channel being programmed.
- prog_sel  in  2  target register: 0 = base address, 1 = base count, 2 = mode, 3 = reserved (write ignored).
- prog_data  in  AW  write data; mode uses bits [1:0].
- tc_clr  in  1  clears all tc_status bits.
- hrq  out  1  hold request to the CPU.
- dack  out  NCH  registered acknowledge for the active channel.
- addr  out  AW  transfer address.
- memr_n, memw_n, ior_n, iow_n  out  1 each  active-low bus strobes.
- eop_n  out  1  active-low terminal-count pulse.
- tc_status  out  NCH  sticky terminal-count flags.
- busy  out  1  high in every state except SI.

Behaviour:
Reset (asynchronous, reset_n low):
- State goes to SI.
- hrq = 0, dack = 0, addr = 0.
- All strobes = 1, eop_n = 1, tc_status = 0.
- All current/base address and count registers = 0; all modes = 00.
- Reset mid-transfer aborts immediately. No address/count update, no TC.

Mode per channel (2 bits):
- 01 write (IO to memory): ior_n and memw_n.
- 10 read (memory to IO): memr_n and iow_n.
- 00 and 11 verify: no strobes; the cycle otherwise runs normally.

FSM, one state per clock:
- SI: if dack_in != 0, go to S0 and set hrq = 1.
- S0: hold hrq = 1.
  - hlda = 1 and dack_in != 0: latch the channel as the lowest set bit of dack_in, go to S1.
  - hlda = 1 and dack_in == 0 (request withdrawn): hrq = 0, go to SI.
  - hlda = 0: stay in S0 indefinitely.
- S1: addr = current address of the latched channel. dack = one-hot of the latched channel; dack stays high through S4.
- S2: assert the read strobe for the mode (ior_n or memr_n).
- S3: additionally assert the write strobe.
  - ready = 0: go to SW.
  - ready = 1: go to S4.
- SW: hold all strobes; return to S4 when ready = 1.
- S4: deassert all strobes. On the S4-to-SI edge:
  - current address += 1, wrapping from all-ones to 0.
  - current count -= 1.
  - If count was 0 before the decrement (it wraps to all-ones), this is terminal count.
- Terminal count:
  - eop_n = 0 for the S4 cycle only.
  - tc_status[ch] is set.
  - Current address and count reload from base.
- After S4: hrq = 0, dack = 0, go to SI. This is single-transfer mode: every transfer re-arbitrates.

Transfer length and latency:
- A programmed count of N gives N+1 transfers.
- Latency from dack_in assertion to dack high is at least 3 clocks (SI, S0, S1).

Programming (prog_we = 1):
- Base address write also loads the current address.
- Base count write also loads the current count.
- While busy = 1, writes to the latched channel are ignored; writes to other channels are accepted.

tc_status:
- tc_clr = 1 clears all bits.
- If tc_clr and a new TC set occur in the same cycle, the set wins.

Changes to dack_in after the channel is latched are ignored until SI.

Test Plan:
1. Reset, program ch0: addr 0x1000, count 0x0002, mode 01. Hold dack_in = 0001, hlda = 1 from S0 onward, ready = 1 -> 3 transfers at addr 0x1000, 0x1001, 0x1002. Each has ior_n and memw_n low in S3. eop_n is low only in the third S4. tc_status = 0001. Current address reloads to 0x1000.
2. ch2 mode 10, count 0, ready low for 3 cycles in S3 -> exactly 3 SW cycles. memr_n and iow_n stay low throughout. Single transfer, then TC.
3. ch1 programmed addr 0xFFFF, count 1 -> transfers at 0xFFFF then 0x0000 (wrap). TC on the second transfer.
4. dack_in = 0100, hlda withheld 5 cycles, then dack_in drops to 0 before hlda -> hrq falls, return to SI. No strobes, no dack.
5. During an active ch3 transfer, write ch3 base address and ch0 base address -> ch3 write ignored, ch0 updated. Assert reset_n low in S3 -> all outputs return to reset values immediately.
6. Verify mode (00) on ch1 -> no strobes asserted; address and count still update. tc_clr pulsed in the same cycle as a TC -> the tc_status bit stays set.
